fortuna_pool_feeder: RTL

FORTUNA_POOL_FEEDER -- requirements
Module: fortuna_pool_feeder

---
 rtl/fortuna_pool_feeder.sv | 114 +++++++++++
 1 files changed

// File: rtl/fortuna_pool_feeder.sv
// Entropy pool feeder: packs 32 input bytes into a block, hands it to a double-SHA-256
// stage, and presents the digest as a reseed value with a valid/ready handshake.
module fortuna_pool_feeder #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic         hash_init,
  output logic [255:0] hash_block,
  input  logic         hash_done,
  input  logic [255:0] hash_digest,
  output logic         seed_valid,
  output logic [255:0] seed,
  input  logic         seed_ready,
  output logic [31:0]  seed_count,
  output logic [5:0]   fill_level,
  output logic         timeout_err
);

  typedef enum logic [1:0] {StFill, StStart, StWait, StOut} state_e;

  localparam logic [9:0] TimeoutVal = 10'(TIMEOUT_CYCLES);

  state_e         state_q, state_d;
  logic [255:0]   pool_q, pool_d;
  logic [5:0]     fill_q, fill_d;
  logic [255:0]   seed_q, seed_d;
  logic [31:0]    count_q, count_d;
  logic [9:0]     wait_cnt_q, wait_cnt_d;
  logic           timeout_q, timeout_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StFill;
      pool_q     <= '0;
      fill_q     <= '0;
      seed_q     <= '0;
      count_q    <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pool_q     <= pool_d;
      fill_q     <= fill_d;
      seed_q     <= seed_d;
      count_q    <= count_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pool_d     = pool_q;
    fill_d     = fill_q;
    seed_d     = seed_q;
    count_d    = count_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;

    unique case (state_q)
      StFill: begin
        if (in_valid) begin
          // Shift left so the first byte ends up in the top byte lane.
          pool_d = {pool_q[247:0], in_data};
          fill_d = fill_q + 6'd1;
          if (fill_q == 6'd31) begin
            state_d = StStart;
          end
        end
      end
      StStart: begin
        wait_cnt_d = '0;
        state_d    = StWait;
      end
      StWait: begin
        wait_cnt_d = wait_cnt_q + 10'd1;
        if (hash_done) begin
          seed_d  = hash_digest;
          state_d = StOut;
        end else if (wait_cnt_q + 10'd1 == TimeoutVal) begin
          timeout_d = 1'b1;
          pool_d    = '0;
          fill_d    = '0;
          state_d   = StFill;
        end
      end
      StOut: begin
        if (seed_ready) begin
          if (count_q != 32'hFFFF_FFFF) begin
            count_d = count_q + 32'd1;
          end
          pool_d  = '0;
          fill_d  = '0;
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  assign in_ready    = (state_q == StFill);
  assign hash_init   = (state_q == StStart);
  assign seed_valid  = (state_q == StOut);
  assign hash_block  = pool_q;
  assign seed        = seed_q;
  assign seed_count  = count_q;
  assign fill_level  = fill_q;
  assign timeout_err = timeout_q;

endmodule
